// File: rtl/morse_encoder_gen_if.sv
// Control and waveform bundle for morse_encoder_gen.
//   master: drives Start/Stop/Repeat/Letter, observes the waveform and status.
//   slave : the encoder side.
// Signals:
//   Start, Stop, Repeat  request / abort / continuous-resend controls
//   Letter[5:0]          0-25 = A-Z, 26-35 = digits 0-9, 36-63 invalid
//   DotDashOut           Morse waveform (1 = tone on)
//   NewBitOut            pulse in the first cycle of every emitted unit
//   Busy, Done, Error    status / end-of-transmission / bad-symbol pulses
interface morse_encoder_gen_if;
  logic       Start;
  logic       Stop;
  logic       Repeat;
  logic [5:0] Letter;
  logic       DotDashOut;
  logic       NewBitOut;
  logic       Busy;
  logic       Done;
  logic       Error;

  modport master (
    output Start, Stop, Repeat, Letter,
    input  DotDashOut, NewBitOut, Busy, Done, Error
  );

  modport slave (
    input  Start, Stop, Repeat, Letter,
    output DotDashOut, NewBitOut, Busy, Done, Error
  );
endinterface

// File: rtl/morse_encoder_gen.sv
// Parametrised Morse encoder for A-Z and 0-9.
// Each symbol is stored as an MSB-first on/off unit pattern plus its length.
// The pattern is shifted out one unit per TICKS_PER_UNIT cycles; an optional
// repeat mode inserts GAP_UNITS off-units and resends the latched symbol.
// Ports:
//   ClockIn  clock, all state changes on the rising edge
//   Reset    asynchronous active-low reset
//   bus      morse_encoder_gen_if.slave (controls in, waveform/status out)
module morse_encoder_gen #(
  parameter int TICKS_PER_UNIT = 4,
  parameter int MAX_BITS       = 20,
  parameter int GAP_UNITS      = 3
) (
  input  logic                  ClockIn,
  input  logic                  Reset,
  morse_encoder_gen_if.slave    bus
);

  localparam int TW = $clog2(TICKS_PER_UNIT) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [4:0]    GAP_LAST  = 5'(GAP_UNITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Symbol ROM. Each entry is described by its element list (n elements,
  // element n-1 first, 1 = dash) and expanded into the unit pattern:
  // dot = 1, dash = 111, a single 0 between elements, left-aligned.
  // The loop is constant-bounded, so this collapses to a lookup table.
  function automatic logic [MAX_BITS+4:0] rom(input logic [5:0] sym);
    logic [2:0]          n;
    logic [4:0]          e;
    logic [MAX_BITS-1:0] p;
    int                  len;
    n = 3'd0;
    e = 5'd0;
    case (sym)
      6'd0:  {n, e} = {3'd2, 5'b00001}; // A .-
      6'd1:  {n, e} = {3'd4, 5'b01000}; // B -...
      6'd2:  {n, e} = {3'd4, 5'b01010}; // C -.-.
      6'd3:  {n, e} = {3'd3, 5'b00100}; // D -..
      6'd4:  {n, e} = {3'd1, 5'b00000}; // E .
      6'd5:  {n, e} = {3'd4, 5'b00010}; // F ..-.
      6'd6:  {n, e} = {3'd3, 5'b00110}; // G --.
      6'd7:  {n, e} = {3'd4, 5'b00000}; // H ....
      6'd8:  {n, e} = {3'd2, 5'b00000}; // I ..
      6'd9:  {n, e} = {3'd4, 5'b00111}; // J .---
      6'd10: {n, e} = {3'd3, 5'b00101}; // K -.-
      6'd11: {n, e} = {3'd4, 5'b00100}; // L .-..
      6'd12: {n, e} = {3'd2, 5'b00011}; // M --
      6'd13: {n, e} = {3'd2, 5'b00010}; // N -.
      6'd14: {n, e} = {3'd3, 5'b00111}; // O ---
      6'd15: {n, e} = {3'd4, 5'b00110}; // P .--.
      6'd16: {n, e} = {3'd4, 5'b01101}; // Q --.-
      6'd17: {n, e} = {3'd3, 5'b00010}; // R .-.
      6'd18: {n, e} = {3'd3, 5'b00000}; // S ...
      6'd19: {n, e} = {3'd1, 5'b00001}; // T -
      6'd20: {n, e} = {3'd3, 5'b00001}; // U ..-
      6'd21: {n, e} = {3'd4, 5'b00001}; // V ...-
      6'd22: {n, e} = {3'd3, 5'b00011}; // W .--
      6'd23: {n, e} = {3'd4, 5'b01001}; // X -..-
      6'd24: {n, e} = {3'd4, 5'b01011}; // Y -.--
      6'd25: {n, e} = {3'd4, 5'b01100}; // Z --..
      6'd26: {n, e} = {3'd5, 5'b11111}; // 0 -----
      6'd27: {n, e} = {3'd5, 5'b01111}; // 1 .----
      6'd28: {n, e} = {3'd5, 5'b00111}; // 2 ..---
      6'd29: {n, e} = {3'd5, 5'b00011}; // 3 ...--
      6'd30: {n, e} = {3'd5, 5'b00001}; // 4 ....-
      6'd31: {n, e} = {3'd5, 5'b00000}; // 5 .....
      6'd32: {n, e} = {3'd5, 5'b10000}; // 6 -....
      6'd33: {n, e} = {3'd5, 5'b11000}; // 7 --...
      6'd34: {n, e} = {3'd5, 5'b11100}; // 8 ---..
      6'd35: {n, e} = {3'd5, 5'b11110}; // 9 ----.
      default: {n, e} = {3'd0, 5'b00000};
    endcase
    p   = '0;
    len = 0;
    for (int i = 4; i >= 0; i--) begin
      if (i < int'(n)) begin
        if (len != 0) begin
          p   = p << 1;
          len = len + 1;
        end
        if (e[i]) begin
          p   = (p << 3) | MAX_BITS'(7);
          len = len + 3;
        end else begin
          p   = (p << 1) | MAX_BITS'(1);
          len = len + 1;
        end
      end
    end
    p = p << (MAX_BITS - len);
    return {5'(len), p};
  endfunction

  logic [1:0]          state;
  logic [MAX_BITS-1:0] pat;   // current unit sits at the MSB
  logic [4:0]          len;
  logic [4:0]          unit;  // unit index in SEND, gap-unit index in GAP
  logic [TW-1:0]       tick;
  logic [5:0]          sym;   // latched symbol, used to reload on repeat

  logic [MAX_BITS+4:0] rom_new;
  logic [MAX_BITS+4:0] rom_old;

  always_comb begin
    rom_new = rom(bus.Letter);
    rom_old = rom(sym);
  end

  // Gating by state makes Stop and Reset silence the output immediately,
  // regardless of what is left in the pattern register.
  assign bus.DotDashOut = (state == SEND) & pat[MAX_BITS-1];
  assign bus.Busy       = (state != IDLE);

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      pat           <= '0;
      len           <= '0;
      unit          <= '0;
      tick          <= '0;
      sym           <= '0;
      bus.NewBitOut <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Error     <= 1'b0;
    end else begin
      bus.NewBitOut <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Error     <= 1'b0;
      case (state)
        IDLE: begin
          // Stop has priority: with Stop high nothing starts and no Error.
          if (bus.Start && !bus.Stop) begin
            if (bus.Letter < 6'd36) begin
              state         <= SEND;
              sym           <= bus.Letter;
              pat           <= rom_new[MAX_BITS-1:0];
              len           <= rom_new[MAX_BITS+4:MAX_BITS];
              unit          <= '0;
              tick          <= '0;
              bus.NewBitOut <= 1'b1;
            end else begin
              bus.Error <= 1'b1;
            end
          end
        end
        SEND: begin
          if (bus.Stop) begin
            state <= IDLE;
          end else if (tick != TICK_LAST) begin
            tick <= tick + 1'b1;
          end else begin
            tick <= '0;
            if (unit == len - 5'd1) begin
              unit <= '0;
              if (bus.Repeat) begin
                state         <= GAP;
                bus.NewBitOut <= 1'b1;
              end else begin
                state    <= IDLE;
                bus.Done <= 1'b1;
              end
            end else begin
              unit          <= unit + 5'd1;
              pat           <= pat << 1;
              bus.NewBitOut <= 1'b1;
            end
          end
        end
        GAP: begin
          if (bus.Stop) begin
            state <= IDLE;
          end else if (tick != TICK_LAST) begin
            tick <= tick + 1'b1;
          end else begin
            tick          <= '0;
            bus.NewBitOut <= 1'b1;
            if (unit == GAP_LAST) begin
              // Repeat was already committed at the end of SEND.
              state <= SEND;
              unit  <= '0;
              pat   <= rom_old[MAX_BITS-1:0];
              len   <= rom_old[MAX_BITS+4:MAX_BITS];
            end else begin
              unit <= unit + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_encoder_gen.sv
// Bench for morse_encoder_gen: two instances (TICKS_PER_UNIT = 2 and 1).
// A transaction builder derives the expected per-cycle waveform from the
// dot/dash text of each symbol and queues it; a monitor pops one entry per
// cycle per instance and compares (empty queue = idle, all outputs 0).
module tb_morse_encoder_gen;
  typedef logic [4:0] ent_t; // {DotDashOut, NewBitOut, Busy, Done, Error}

  localparam int GAPU = 3;

  logic ClockIn = 1'b0;
  logic Reset   = 1'b0;
  always #5 ClockIn = ~ClockIn;

  morse_encoder_gen_if ifa ();
  morse_encoder_gen_if ifb ();

  morse_encoder_gen #(.TICKS_PER_UNIT(2), .MAX_BITS(20), .GAP_UNITS(GAPU)) dut_a (
    .ClockIn(ClockIn), .Reset(Reset), .bus(ifa));
  morse_encoder_gen #(.TICKS_PER_UNIT(1), .MAX_BITS(20), .GAP_UNITS(GAPU)) dut_b (
    .ClockIn(ClockIn), .Reset(Reset), .bus(ifb));

  string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
    "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
    "-", "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
    "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  ent_t qa[$];
  ent_t qb[$];
  ent_t wq[$];
  bit   rq[$];
  int   errors = 0;
  int   checks = 0;

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input ent_t got, input ent_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b (dd,nb,busy,done,err)", name, $time, got, exp);
    end
  endtask

  initial begin
    ent_t ea, eb;
    forever begin
      @(negedge ClockIn or negedge Reset);
      if (ClockIn) begin
        // reset dropped mid-cycle: outputs must already be clear
        #1;
        cmp("async_reset_a", {ifa.DotDashOut, ifa.NewBitOut, ifa.Busy, ifa.Done, ifa.Error}, '0);
        cmp("async_reset_b", {ifb.DotDashOut, ifb.NewBitOut, ifb.Busy, ifb.Done, ifb.Error}, '0);
      end else begin
        ea = (qa.size() != 0) ? qa.pop_front() : '0;
        eb = (qb.size() != 0) ? qb.pop_front() : '0;
        cmp("cycle_a", {ifa.DotDashOut, ifa.NewBitOut, ifa.Busy, ifa.Done, ifa.Error}, ea);
        cmp("cycle_b", {ifb.DotDashOut, ifb.NewBitOut, ifb.Busy, ifb.Done, ifb.Error}, eb);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int tpu_of(input int sel);
    return (sel == 0) ? 2 : 1;
  endfunction

  task automatic add_unit(input logic v, input bit rp, input int tpu);
    ent_t e;
    for (int t = 0; t < tpu; t++) begin
      e    = '0;
      e[4] = v;
      e[3] = (t == 0);
      e[2] = 1'b1;
      wq.push_back(e);
      rq.push_back(rp);
    end
  endtask

  // Expected waveform for nsends copies of a symbol; Repeat is held high
  // through every send but the last and dropped at the start of the final gap.
  // stop_at >= 0 raises Stop in that cycle of the waveform.
  task automatic build(input int letter, input int nsends, input int tpu, input int stop_at);
    string c;
    bit    rp;
    c = codes[letter];
    wq.delete();
    rq.delete();
    for (int s = 0; s < nsends; s++) begin
      rp = (s < nsends - 1);
      if (s > 0) for (int g = 0; g < GAPU; g++) add_unit(1'b0, rp, tpu);
      for (int j = 0; j < c.len(); j++) begin
        if (j > 0) add_unit(1'b0, rp, tpu);
        if (c[j] == "-") repeat (3) add_unit(1'b1, rp, tpu);
        else add_unit(1'b1, rp, tpu);
      end
    end
    if (stop_at >= 0 && stop_at < wq.size()) begin
      while (wq.size() > stop_at + 1) begin
        void'(wq.pop_back());
        void'(rq.pop_back());
      end
      wq.push_back(5'b00000);
    end else begin
      wq.push_back(5'b00010);
    end
    rq.push_back(1'b0);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input int sel, input logic st, input logic sp, input logic rp, input logic [5:0] lt);
    if (sel == 0) begin
      ifa.Start = st; ifa.Stop = sp; ifa.Repeat = rp; ifa.Letter = lt;
    end else begin
      ifb.Start = st; ifb.Stop = sp; ifb.Repeat = rp; ifb.Letter = lt;
    end
  endtask

  task automatic push_exp(input int sel, input ent_t e);
    if (sel == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // noise: random Start pulses and Letter values (valid or not) while busy
  task automatic txn(input int sel, input int letter, input int nsends, input int stop_at, input bit noise);
    bit bsy;
    build(letter, nsends, tpu_of(sel), stop_at);
    @(posedge ClockIn); #1;
    push_exp(sel, '0);
    for (int i = 0; i < wq.size(); i++) push_exp(sel, wq[i]);
    drive(sel, 1'b1, 1'b0, 1'b0, 6'(letter));
    for (int i = 0; i < wq.size(); i++) begin
      @(posedge ClockIn); #1;
      bsy = wq[i][2];
      if (noise && bsy)
        drive(sel, 1'($urandom_range(0, 1)), (i == stop_at), rq[i], 6'($urandom_range(0, 63)));
      else
        drive(sel, 1'b0, (i == stop_at), rq[i], 6'(letter));
    end
  endtask

  task automatic err_txn(input int sel, input int letter);
    @(posedge ClockIn); #1;
    push_exp(sel, '0);
    push_exp(sel, 5'b00001);
    drive(sel, 1'b1, 1'b0, 1'b0, 6'(letter));
    @(posedge ClockIn); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 6'(letter));
    @(posedge ClockIn); #1;
  endtask

  task automatic stop_wins(input int sel, input int letter);
    @(posedge ClockIn); #1;
    drive(sel, 1'b1, 1'b1, 1'b0, 6'(letter));
    @(posedge ClockIn); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 6'(letter));
    repeat (2) @(posedge ClockIn);
    #1;
  endtask

  // start a symbol, then pull reset low mid-cycle after r waveform cycles
  task automatic rst_mid(input int letter, input int r);
    build(letter, 1, tpu_of(0), -1);
    @(posedge ClockIn); #1;
    push_exp(0, '0);
    for (int i = 0; i < r; i++) push_exp(0, wq[i]);
    drive(0, 1'b1, 1'b0, 1'b0, 6'(letter));
    for (int i = 0; i < r; i++) begin
      @(posedge ClockIn); #1;
      drive(0, 1'b0, 1'b0, 1'b0, 6'(letter));
    end
    @(posedge ClockIn); #3;
    Reset = 1'b0;
    repeat (2) @(posedge ClockIn);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    int sel, letter, ns, stp;
    drive(0, 1'b0, 1'b0, 1'b0, 6'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 6'd0);
    repeat (3) @(posedge ClockIn);
    #1;
    Reset = 1'b1;
    repeat (2) @(posedge ClockIn);

    txn(0, 0, 1, -1, 1'b0);   // A, 2 ticks/unit
    txn(0, 4, 3, -1, 1'b0);   // E repeated, Repeat dropped in last gap
    txn(1, 26, 1, -1, 1'b0);  // digit 0, 1 tick/unit (longest code)
    txn(1, 4, 2, -1, 1'b0);   // E repeat, NewBitOut every cycle
    err_txn(0, 40);           // invalid symbol
    err_txn(1, 63);
    txn(0, 26, 1, 7, 1'b0);   // Stop mid-send
    txn(0, 4, 2, 4, 1'b0);    // Stop inside the gap
    stop_wins(0, 19);         // Start+Stop in IDLE
    rst_mid(1, 5);            // async reset mid-send
    txn(0, 19, 1, -1, 1'b0);  // T after reset
    txn(0, 2, 1, -1, 1'b1);   // Start/Letter noise during send
    txn(1, 35, 2, -1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        err_txn(sel, int'($urandom_range(36, 63)));
      end else begin
        letter = int'($urandom_range(0, 35));
        ns     = int'($urandom_range(1, 3));
        stp    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
        txn(sel, letter, ns, stp, 1'($urandom_range(0, 1)));
      end
    end

    repeat (4) @(posedge ClockIn);
    #6;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
